// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

   // Control FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Iteration counter width: enough to count 0..width.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage : seq_mul_pkg

// File: rtl/seq_mul_abs.sv
// Conditional two's-complement negate of a W-bit value.
// Used for operand magnitudes and the final result sign fix when
// SEQ_MUL_SIGNED_EN is defined.
module seq_mul_abs
   import seq_mul_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] result
);

   // Negate when requested, otherwise pass the value through.
   always_comb begin
      result = value;
      if (negate) begin
         result = (~value) + {{(W-1){1'b0}}, 1'b1};
      end else begin
         result = value;
      end
   end

endmodule : seq_mul_abs

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product in
// WIDTH+1 cycles with a busy/done handshake.
// Optional feature macro: SEQ_MUL_SIGNED_EN (honour signed_mode and handle
// two's-complement operands via magnitudes plus a final negation).
module seq_multiplier
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t               state_r;
   state_t               state_nxt_s;
   logic                 accept_s;

   logic [WIDTH-1:0]     mcand_r;
   logic [WIDTH-1:0]     mplier_r;
   logic [WIDTH-1:0]     acc_r;
   logic [CW-1:0]        count_r;
   logic                 neg_r;
   logic                 busy_r;
   logic                 done_r;
   logic [2*WIDTH-1:0]   product_r;

   logic [WIDTH:0]       sum_s;
   logic [2*WIDTH-1:0]   acc_full_s;
   logic [2*WIDTH-1:0]   fixed_s;
   logic [WIDTH-1:0]     a_mag_s;
   logic [WIDTH-1:0]     b_mag_s;
   logic                 neg_in_s;

   assign acc_full_s = {acc_r, mplier_r};

`ifdef SEQ_MUL_SIGNED_EN
   // Operands enter the datapath as unsigned magnitudes; the sign of the
   // product is tracked separately in neg_r and applied in FIX.
   assign neg_in_s = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

   seq_mul_abs #(.W(WIDTH)) u_abs_a (
      .value  (a),
      .negate (signed_mode & a[WIDTH-1]),
      .result (a_mag_s)
   );

   seq_mul_abs #(.W(WIDTH)) u_abs_b (
      .value  (b),
      .negate (signed_mode & b[WIDTH-1]),
      .result (b_mag_s)
   );

   seq_mul_abs #(.W(2*WIDTH)) u_abs_p (
      .value  (acc_full_s),
      .negate (neg_r),
      .result (fixed_s)
   );
`else
   // Unsigned-only build: signed_mode is accepted but has no effect.
   logic unused_signed_s;

   assign neg_in_s        = 1'b0;
   assign a_mag_s         = a;
   assign b_mag_s         = b;
   assign fixed_s         = acc_full_s;
   assign unused_signed_s = signed_mode ^ neg_r;
`endif

   // Conditional add of the multiplicand into the upper accumulator half.
   always_comb begin
      sum_s = {1'b0, acc_r};
      if (mplier_r[0]) begin
         sum_s = {1'b0, acc_r} + {1'b0, mcand_r};
      end else begin
         sum_s = {1'b0, acc_r};
      end
   end

   // Next-state logic for the IDLE -> RUN -> FIX -> IDLE sequence.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               accept_s    = 1'b1;
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (count_r == LAST_CNT) begin
               state_nxt_s = FIX;
            end else begin
               state_nxt_s = RUN;
            end
         end
         FIX: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Shift-add datapath, handshake flags and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_r   <= '0;
         mplier_r  <= '0;
         acc_r     <= '0;
         count_r   <= '0;
         neg_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         product_r <= '0;
      end else begin
         done_r <= (state_r == FIX);
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  mcand_r  <= a_mag_s;
                  mplier_r <= b_mag_s;
                  acc_r    <= '0;
                  count_r  <= '0;
                  neg_r    <= neg_in_s;
                  busy_r   <= 1'b1;
               end
            end
            RUN: begin
               // Shift {sum, multiplier} right by one.
               acc_r    <= sum_s[WIDTH:1];
               mplier_r <= {sum_s[0], mplier_r[WIDTH-1:1]};
               count_r  <= count_r + 1'b1;
            end
            FIX: begin
               product_r <= fixed_s;
               busy_r    <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign product = product_r;

endmodule : seq_multiplier
